// File: rtl/servo_adc_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : servo_adc_scheduler_if
//  Description : Handshake bundle between the servo ADC scheduler and the
//                external ADC interface block.
//                  adc_ch   - channel select to the analog mux
//                  adc_req  - conversion request, held until adc_ack
//                  adc_ack  - 1-cycle acknowledge, adc_data valid with it
//                  adc_data - conversion result
//                Modports: master = scheduler side, slave = ADC side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface servo_adc_scheduler_if #(
    parameter int ADC_WIDTH = 12
);
    logic [1:0]           adc_ch;
    logic                 adc_req;
    logic                 adc_ack;
    logic [ADC_WIDTH-1:0] adc_data;

    modport master (
        output adc_ch,
        output adc_req,
        input  adc_ack,
        input  adc_data
    );

    modport slave (
        input  adc_ch,
        input  adc_req,
        output adc_ack,
        output adc_data
    );
endinterface
`default_nettype wire

// File: rtl/servo_adc_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : servo_adc_scheduler
//  Description : Sequences one shared current-sense ADC across 4 servo
//                channels. Each trigger starts one sweep over the channels
//                enabled in ch_en (ascending order). Per channel: select the
//                mux, wait SETTLE_CYCLES, request a conversion and wait for
//                the ack (or give up after TIMEOUT_CYCLES).
//  Ports       : clk, reset (async, active high)
//                trigger, ch_en[3:0], err_clr      - control inputs
//                adc (servo_adc_scheduler_if.master) - ADC handshake
//                i0..i3                             - latest result per channel
//                i_valid (sweep complete pulse), busy
//                overrun (sticky), timeout_err[3:0] (sticky per channel)
//  Options     : SERVO_ADC_SCHED_FILTER_EN - when defined, each result is the
//                2-tap average of the previous result and the new sample; the
//                first sample after reset on a channel is loaded directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module servo_adc_scheduler #(
    parameter int ADC_WIDTH      = 12,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        trigger,
    input  logic [3:0]                  ch_en,
    input  logic                        err_clr,
    servo_adc_scheduler_if.master       adc,
    output logic [ADC_WIDTH-1:0]        i0,
    output logic [ADC_WIDTH-1:0]        i1,
    output logic [ADC_WIDTH-1:0]        i2,
    output logic [ADC_WIDTH-1:0]        i3,
    output logic                        i_valid,
    output logic                        busy,
    output logic                        overrun,
    output logic [3:0]                  timeout_err
);

    // One counter serves both the settle and the ack-timeout phases.
    localparam int c_CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_REQ    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_en;
    logic [1:0]           r_adc_ch;
    logic                 r_adc_req;
    logic [ADC_WIDTH-1:0] r_res [4];

    logic [1:0]           w_first_ch;
    logic [1:0]           w_next_ch;
    logic                 w_has_next;
    logic [ADC_WIDTH-1:0] w_new_res;
    logic                 w_settle_end;
    logic                 w_timeout;

`ifdef SERVO_ADC_SCHED_FILTER_EN
    logic [3:0]           r_loaded;
`endif

    assign adc.adc_ch  = r_adc_ch;
    assign adc.adc_req = r_adc_req;

    assign i0 = r_res[0];
    assign i1 = r_res[1];
    assign i2 = r_res[2];
    assign i3 = r_res[3];

    assign w_settle_end = (r_cnt == c_CNT_W'(SETTLE_CYCLES - 1));
    assign w_timeout    = (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

    // Lowest enabled channel of a new sweep, and next higher enabled channel
    // of the current sweep (descending scan so the lowest match wins).
    always_comb begin
        w_first_ch = 2'd0;
        w_next_ch  = 2'd0;
        w_has_next = 1'b0;
        for (int c = 3; c >= 0; c--) begin
            if (ch_en[c]) begin
                w_first_ch = 2'(c);
            end
            if (r_en[c] && (2'(c) > r_adc_ch)) begin
                w_next_ch  = 2'(c);
                w_has_next = 1'b1;
            end
        end
    end

    always_comb begin
`ifdef SERVO_ADC_SCHED_FILTER_EN
        // Sum in ADC_WIDTH+1 bits so the average cannot overflow.
        w_new_res = r_loaded[r_adc_ch]
                  ? ADC_WIDTH'(({1'b0, r_res[r_adc_ch]} + {1'b0, adc.adc_data}) >> 1)
                  : adc.adc_data;
`else
        w_new_res = adc.adc_data;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_en        <= 4'd0;
            r_adc_ch    <= 2'd0;
            r_adc_req   <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                r_res[c] <= '0;
            end
            i_valid     <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 4'd0;
`ifdef SERVO_ADC_SCHED_FILTER_EN
            r_loaded    <= 4'd0;
`endif
        end else begin
            i_valid <= 1'b0;

            // Clear first so a set event in the same cycle takes priority.
            if (err_clr) begin
                overrun     <= 1'b0;
                timeout_err <= 4'd0;
            end
            if (trigger && (r_state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (trigger) begin
                        if (|ch_en) begin
                            r_en     <= ch_en;
                            r_adc_ch <= w_first_ch;
                            r_cnt    <= '0;
                            busy     <= 1'b1;
                            r_state  <= S_SETTLE;
                        end else begin
                            r_state  <= S_DONE;
                        end
                    end
                end

                S_SETTLE: begin
                    if (w_settle_end) begin
                        r_cnt     <= '0;
                        r_adc_req <= 1'b1;
                        r_state   <= S_REQ;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_REQ: begin
                    // An ack on the expiring cycle is still a valid conversion.
                    if (adc.adc_ack || w_timeout) begin
                        if (adc.adc_ack) begin
                            r_res[r_adc_ch] <= w_new_res;
`ifdef SERVO_ADC_SCHED_FILTER_EN
                            r_loaded[r_adc_ch] <= 1'b1;
`endif
                        end else begin
                            timeout_err[r_adc_ch] <= 1'b1;
                        end
                        r_adc_req <= 1'b0;
                        r_cnt     <= '0;
                        if (w_has_next) begin
                            r_adc_ch <= w_next_ch;
                            r_state  <= S_SETTLE;
                        end else begin
                            r_state  <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    i_valid <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_servo_adc_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo_adc_scheduler
//  Description : Scoreboard bench for servo_adc_scheduler. Stimulus pushes the
//                expected channel order and the expected sweep results; an ADC
//                responder and an i_valid monitor pop and compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_adc_scheduler;

    localparam int ADC_WIDTH      = 12;
    localparam int SETTLE_CYCLES  = 8;
    localparam int TIMEOUT_CYCLES = 255;

    typedef struct packed {
        logic [11:0] r0;
        logic [11:0] r1;
        logic [11:0] r2;
        logic [11:0] r3;
        logic [3:0]  terr;
        logic        ovr;
        logic [7:0]  lat;   // 0 = latency not checked
    } exp_t;

    logic        clk;
    logic        reset;
    logic        trigger;
    logic [3:0]  ch_en;
    logic        err_clr;
    logic [11:0] i0, i1, i2, i3;
    logic        i_valid;
    logic        busy;
    logic        overrun;
    logic [3:0]  timeout_err;

    servo_adc_scheduler_if #(.ADC_WIDTH(ADC_WIDTH)) bus ();

    servo_adc_scheduler #(
        .ADC_WIDTH      (ADC_WIDTH),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trigger     (trigger),
        .ch_en       (ch_en),
        .err_clr     (err_clr),
        .adc         (bus.master),
        .i0          (i0),
        .i1          (i1),
        .i2          (i2),
        .i3          (i3),
        .i_valid     (i_valid),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          trig_cyc = 0;
    int          ack_delay = 3;
    logic [3:0]  mute_mask = 4'd0;
    logic [11:0] data_tbl [4];

    exp_t        exp_q [$];
    logic [1:0]  exp_ch_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ADC model: acks ack_delay cycles after adc_req rises unless the channel
    // is muted; also checks channel order and the timeout request length.
    initial begin : adc_model
        logic [1:0] cur_ch;
        logic       cur_mute;
        logic       prev_req;
        int         wait_cnt;
        int         req_len;
        cur_ch = 2'd0; cur_mute = 1'b0; prev_req = 1'b0; wait_cnt = 0; req_len = 0;
        bus.adc_ack  = 1'b0;
        bus.adc_data = '0;
        forever begin
            @(negedge clk);
            bus.adc_ack = 1'b0;
            if (bus.adc_req) begin
                if (!prev_req) begin
                    cur_ch   = bus.adc_ch;
                    cur_mute = mute_mask[cur_ch];
                    wait_cnt = ack_delay;
                    req_len  = 0;
                    if (exp_ch_q.size() == 0) begin
                        check("unexpected_req_ch", 32'(cur_ch), 32'hFFFF);
                    end else begin
                        check("req_channel", 32'(cur_ch), 32'(exp_ch_q.pop_front()));
                    end
                end
                req_len++;
                if (!cur_mute && wait_cnt > 0) begin
                    if (wait_cnt == 1) begin
                        bus.adc_ack  = 1'b1;
                        bus.adc_data = data_tbl[cur_ch];
                    end
                    wait_cnt--;
                end
            end else if (prev_req) begin
                if (cur_mute && !reset) begin
                    check("timeout_req_len", 32'(req_len), 32'(TIMEOUT_CYCLES));
                end
                wait_cnt = 0;
            end
            prev_req = bus.adc_req;
        end
    end

    // Sweep-complete monitor.
    initial begin : result_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_i_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("i0", 32'(i0), 32'(e.r0));
                    check("i1", 32'(i1), 32'(e.r1));
                    check("i2", 32'(i2), 32'(e.r2));
                    check("i3", 32'(i3), 32'(e.r3));
                    check("timeout_err", 32'(timeout_err), 32'(e.terr));
                    check("overrun", 32'(overrun), 32'(e.ovr));
                    check("busy_at_done", 32'(busy), 32'd0);
                    if (e.lat != 8'd0) begin
                        check("latency", 32'(cyc - trig_cyc), 32'(e.lat));
                    end
                end
            end
        end
    end

    task automatic sweep(input logic [3:0] en, input logic [3:0] mute,
                         input logic [11:0] e0, input logic [11:0] e1,
                         input logic [11:0] e2, input logic [11:0] e3,
                         input logic [3:0] eterr, input logic eovr, input int elat);
        exp_t e;
        e.r0 = e0; e.r1 = e1; e.r2 = e2; e.r3 = e3;
        e.terr = eterr; e.ovr = eovr; e.lat = 8'(elat);
        exp_q.push_back(e);
        for (int c = 0; c < 4; c++) begin
            if (en[c]) exp_ch_q.push_back(2'(c));
        end
        mute_mask = mute;
        @(negedge clk);
        trigger  = 1'b1;
        ch_en    = en;
        trig_cyc = cyc;
        @(negedge clk);
        trigger  = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 3000 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("sweep_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin : stimulus
        reset = 1'b1; trigger = 1'b0; ch_en = 4'd0; err_clr = 1'b0;
        for (int c = 0; c < 4; c++) data_tbl[c] = 12'h000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_i0", 32'(i0), 32'd0);
        check("rst_i1", 32'(i1), 32'd0);
        check("rst_i2", 32'(i2), 32'd0);
        check("rst_i3", 32'(i3), 32'd0);
        check("rst_i_valid", 32'(i_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_adc_req", 32'(bus.adc_req), 32'd0);
        check("rst_adc_ch", 32'(bus.adc_ch), 32'd0);

        // T1: all four channels, ascending order.
        data_tbl[0] = 12'h100; data_tbl[1] = 12'h101; data_tbl[2] = 12'h102; data_tbl[3] = 12'h103;
        sweep(4'b1111, 4'b0000, 12'h100, 12'h101, 12'h102, 12'h103, 4'b0000, 1'b0, 0);
        @(negedge clk);
        check("busy_during_sweep", 32'(busy), 32'd1);
        wait_done();

        // Single channel latency: 1 + SETTLE + k + 1 with k = 3.
        data_tbl[0] = 12'h0AA;
`ifdef SERVO_ADC_SCHED_FILTER_EN
        sweep(4'b0001, 4'b0000, 12'h0D5, 12'h101, 12'h102, 12'h103, 4'b0000, 1'b0, 13);
`else
        sweep(4'b0001, 4'b0000, 12'h0AA, 12'h101, 12'h102, 12'h103, 4'b0000, 1'b0, 13);
`endif
        wait_done();

        // T2: ch1 and ch3 only; ch0/ch2 data must not be used.
        data_tbl[0] = 12'h7FF; data_tbl[1] = 12'h211; data_tbl[2] = 12'h7FF; data_tbl[3] = 12'h233;
`ifdef SERVO_ADC_SCHED_FILTER_EN
        sweep(4'b1010, 4'b0000, 12'h0D5, 12'h189, 12'h102, 12'h19B, 4'b0000, 1'b0, 0);
`else
        sweep(4'b1010, 4'b0000, 12'h0AA, 12'h211, 12'h102, 12'h233, 4'b0000, 1'b0, 0);
`endif
        wait_done();

        // T3: ch2 never acks, ch3 still converted.
        data_tbl[3] = 12'h3C3;
`ifdef SERVO_ADC_SCHED_FILTER_EN
        sweep(4'b1100, 4'b0100, 12'h0D5, 12'h189, 12'h102, 12'h2AF, 4'b0100, 1'b0, 0);
`else
        sweep(4'b1100, 4'b0100, 12'h0AA, 12'h211, 12'h102, 12'h3C3, 4'b0100, 1'b0, 0);
`endif
        wait_done();
        pulse_err_clr();
        check("timeout_err_cleared", 32'(timeout_err), 32'd0);

        // T4: second trigger mid-sweep with err_clr in the same cycle.
        data_tbl[0] = 12'h010; data_tbl[1] = 12'h020;
`ifdef SERVO_ADC_SCHED_FILTER_EN
        sweep(4'b0011, 4'b0000, 12'h072, 12'h0D4, 12'h102, 12'h2AF, 4'b0000, 1'b1, 0);
`else
        sweep(4'b0011, 4'b0000, 12'h010, 12'h020, 12'h102, 12'h3C3, 4'b0000, 1'b1, 0);
`endif
        repeat (4) @(negedge clk);
        trigger = 1'b1; err_clr = 1'b1; ch_en = 4'b1111;
        @(negedge clk);
        trigger = 1'b0; err_clr = 1'b0;
        check("overrun_set_wins", 32'(overrun), 32'd1);
        wait_done();
        pulse_err_clr();
        check("overrun_cleared", 32'(overrun), 32'd0);

        // Empty enable mask: i_valid on the next cycle, results unchanged.
`ifdef SERVO_ADC_SCHED_FILTER_EN
        sweep(4'b0000, 4'b0000, 12'h072, 12'h0D4, 12'h102, 12'h2AF, 4'b0000, 1'b0, 2);
`else
        sweep(4'b0000, 4'b0000, 12'h010, 12'h020, 12'h102, 12'h3C3, 4'b0000, 1'b0, 2);
`endif
        wait_done();

        // T5: reset while adc_req is high.
        ack_delay = 100;
        sweep(4'b0001, 4'b0000, 12'h000, 12'h000, 12'h000, 12'h000, 4'b0000, 1'b0, 0);
        for (int n = 0; n < 100 && !bus.adc_req; n++) @(negedge clk);
        check("t5_req_seen", 32'(bus.adc_req), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_adc_req", 32'(bus.adc_req), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_i_all", 32'({i0, i1, i2}), 32'd0);
        check("t5_i3", 32'(i3), 32'd0);
        exp_q.delete();
        exp_ch_q.delete();
        @(negedge clk);
        reset = 1'b0;
        ack_delay = 3;
        data_tbl[2] = 12'h0F0;
        sweep(4'b0100, 4'b0000, 12'h000, 12'h000, 12'h0F0, 12'h000, 4'b0000, 1'b0, 0);
        wait_done();

        // T6: consecutive ch0 samples.
        data_tbl[0] = 12'h200;
        sweep(4'b0001, 4'b0000, 12'h200, 12'h000, 12'h0F0, 12'h000, 4'b0000, 1'b0, 0);
        wait_done();
        data_tbl[0] = 12'h300;
`ifdef SERVO_ADC_SCHED_FILTER_EN
        sweep(4'b0001, 4'b0000, 12'h280, 12'h000, 12'h0F0, 12'h000, 4'b0000, 1'b0, 0);
`else
        sweep(4'b0001, 4'b0000, 12'h300, 12'h000, 12'h0F0, 12'h000, 4'b0000, 1'b0, 0);
`endif
        wait_done();

        check("leftover_req_expect", 32'(exp_ch_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
